mux_scan_sequencer: RTL and testbench
=====================================

// Module: mux_scan_sequencer
// PURPOSE
//  Sequencer wrapped around the 8:1 bit-select mux: drives the mux selector and captures its output bit.
//  - On start, steps the selector 0..NBITS-1 and samples the mux output (bit_in) once per step.
//  - Assembles the sampled bits into a parallel word and presents it on a valid/ack handshake.
//  - Sits between the top-level pin wrapper and the mux core.
// PARAMETERS
//  SEL_W     3   selector width; NBITS = 2**SEL_W (8)
//  DIV       0   extra hold cycles per selector step; each step lasts DIV+1 clk cycles (0..255)
// PORTS
//  clk       in   1       system clock
//  rst       in   1       asynchronous, active-high reset
//  start     in   1       scan request; sampled only in IDLE, or in DONE together with ack
//  bit_in    in   1       mux output for the current sel (combinational path from mux)
//  sel       out  SEL_W   selector to mux; registered
//  busy      out  1       high in SCAN
//  data_out  out  NBITS   captured word; bit k = bit_in sampled while sel==k
//  valid     out  1       data_out holds a complete scan; high in DONE
//  ack       in   1       consumer accepts data_out; meaningful only while valid
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, sel=0, busy=0, valid=0, data_out=0, parity=0, prescale cnt=0.
//  - FSM states IDLE, SCAN, DONE:
//    IDLE -> SCAN on start; sel=0, step cnt=0, busy=1 after that edge.
//    SCAN: prescale cnt counts 0..DIV; on the edge where cnt==DIV, sample bit_in into shift reg at index sel.
//      Sample when sel<NBITS-1: sel+1, cnt=0.
//      Sample when sel==NBITS-1: load data_out from shift reg incl. this bit; sel wraps to 0; valid=1, busy=0 -> DONE.
//    DONE: hold data_out, valid until ack.
//      ack & !start -> IDLE, valid=0.
//      ack & start -> SCAN directly (back-to-back), valid=0, sel=0.
//      start without ack -> ignored.
//  - Latency: start edge to valid edge = NBITS*(DIV+1) cycles (8 for defaults).
//  - start while in SCAN is ignored; ack outside DONE is ignored.
//  - data_out changes only on the completion edge; never partially updated while valid=1.
//  - sel is stable for the full DIV+1 cycles of a step, so bit_in settles before sampling.
//  - Reset mid-scan: immediate return to reset values; partial word discarded, no valid pulse.
//  - bit_in changing mid-step: only the value at the sampling edge is used.
// CONFIGURATION
//  SCAN_PARITY_EN defined:
//    - Adds output port parity (1 bit) = XOR of data_out.
//    - parity is loaded on the same edge as data_out; reset value 0.
//  SCAN_PARITY_EN undefined:
//    - No parity port, no parity logic.
//    - All other behaviour unchanged.
// STRUCTURE
//  - Package mux_scan_pkg:
//    - state enum (ST_IDLE, ST_SCAN, ST_DONE)
//    - default SEL_W
//    - localparam NBITS derivation
//  - Sub-module scan_prescaler: counts 0..DIV and emits a one-cycle step pulse while enabled.
//    - Cleared by rst and on leaving SCAN.
//    - DIV=0 -> pulse every cycle.
//  - Top holds the FSM, sel counter, shift register and output registers.
// TESTING
//  - Reset: rst=1 mid-operation -> sel=0, valid=0, busy=0, data_out=0 within same cycle (async).
//  - Basic scan, DIV=0: mux model on 8'hA5, start 1 cycle -> valid rises 8 cycles later, data_out=8'hA5, sel seq 0..7.
//  - Prescale: DIV=3, word 8'h3C -> each sel value held 4 cycles; valid after 32 cycles; data_out=8'h3C.
//  - Handshake: hold ack=0 for 10 cycles in DONE with start pulses -> data_out/valid stable, no new scan.
//    Then ack=1 -> IDLE.
//  - Back-to-back: ack=1 & start=1 in DONE with word changed to 8'h5A -> second valid 8 cycles later, data_out=8'h5A.
//  - Parity (SCAN_PARITY_EN): word 8'h07 -> parity=1; word 8'hFF -> parity=0.
//    Build without macro compiles with no parity port.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared types and sizing for the mux scan sequencer.
// Optional feature macro used by the top: SCAN_PARITY_EN.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE
  } state_t;

  localparam int unsigned SEL_W_DEFAULT = 3;
  localparam int unsigned NBITS_DEFAULT = 2 ** SEL_W_DEFAULT;

  // Number of mux inputs addressed by a selector of the given width.
  function automatic int unsigned nbits(input int unsigned sel_w);
    return 32'd1 << sel_w;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Step-rate prescaler: counts 0..DIV while enabled and flags the last cycle of each step.
module scan_prescaler #(
  parameter int unsigned DIV = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic step_c
);

  localparam int unsigned CNT_W = 8;

  logic [CNT_W-1:0] cnt;
  logic             at_end_c;

  assign at_end_c = (cnt == CNT_W'(DIV));
  assign step_c   = en && at_end_c;

  // Counter parks at zero whenever the sequencer is not scanning.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en || at_end_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Walks the bit-select mux selector across all inputs and presents the captured word on valid/ack.
// Define SCAN_PARITY_EN to add a registered parity output (XOR of data_out).
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter  int unsigned SEL_W = SEL_W_DEFAULT,
  parameter  int unsigned DIV   = 0,
  localparam int unsigned NBITS = nbits(SEL_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bit_in,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic [NBITS-1:0] data_out,
  output logic             valid,
  input  logic             ack
`ifdef SCAN_PARITY_EN
  ,
  output logic             parity
`endif
);

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NBITS - 1);

  state_t           state;
  logic [NBITS-1:0] shift_q;
  logic [NBITS-1:0] word_c;
  logic             step_c;
  logic             scanning_c;
  logic             complete_c;

  assign scanning_c = (state == ST_SCAN);
  assign complete_c = scanning_c && step_c && (sel == SEL_LAST);

  scan_prescaler #(
    .DIV(DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .en    (scanning_c),
    .step_c(step_c)
  );

  // Shift register image including the bit being sampled this cycle.
  always_comb begin
    word_c      = shift_q;
    word_c[sel] = bit_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      sel      <= '0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      data_out <= '0;
      shift_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_SCAN;
            sel   <= '0;
            busy  <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (step_c) begin
            shift_q <= word_c;
            if (sel == SEL_LAST) begin
              data_out <= word_c;
              sel      <= '0;
              valid    <= 1'b1;
              busy     <= 1'b0;
              state    <= ST_DONE;
            end else begin
              sel <= sel + SEL_W'(1);
            end
          end
        end
        ST_DONE: begin
          // A start that arrives with ack launches the next scan without an idle cycle.
          if (ack) begin
            valid <= 1'b0;
            if (start) begin
              state <= ST_SCAN;
              sel   <= '0;
              busy  <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SCAN_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity <= 1'b0;
    end else if (complete_c) begin
      parity <= ^word_c;
    end
  end
`endif

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: two instances (DIV=0 and DIV=3) checked every cycle against a timeline model.
module tb_mux_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start    [2];
  logic       ack      [2];
  logic [7:0] word     [2];
  logic       bit_in   [2];
  logic [2:0] sel      [2];
  logic       busy     [2];
  logic [7:0] data_out [2];
  logic       valid    [2];
`ifdef SCAN_PARITY_EN
  logic       parity   [2];
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  // Mux models: each selector picks one bit of that instance's word.
  assign bit_in[0] = word[0][sel[0]];
  assign bit_in[1] = word[1][sel[1]];

  mux_scan_sequencer #(.SEL_W(3), .DIV(0)) u_div0 (
    .clk(clk), .rst(rst), .start(start[0]), .bit_in(bit_in[0]), .sel(sel[0]),
    .busy(busy[0]), .data_out(data_out[0]), .valid(valid[0]), .ack(ack[0])
`ifdef SCAN_PARITY_EN
    , .parity(parity[0])
`endif
  );

  mux_scan_sequencer #(.SEL_W(3), .DIV(3)) u_div3 (
    .clk(clk), .rst(rst), .start(start[1]), .bit_in(bit_in[1]), .sel(sel[1]),
    .busy(busy[1]), .data_out(data_out[1]), .valid(valid[1]), .ack(ack[1])
`ifdef SCAN_PARITY_EN
    , .parity(parity[1])
`endif
  );

  // Timeline model: phase 0 idle, 1 scanning (t cycles since start), 2 holding a result.
  int         divs  [2] = '{0, 3};
  int         phase [2] = '{0, 0};
  int         t     [2] = '{0, 0};
  logic [7:0] capw  [2] = '{8'h00, 8'h00};
  logic [7:0] mdata [2] = '{8'h00, 8'h00};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        phase[i] = 0;
        t[i]     = 0;
        mdata[i] = 8'h00;
      end else begin
        case (phase[i])
          0: if (start[i]) begin
               phase[i] = 1; t[i] = 0; capw[i] = word[i];
             end
          1: begin
               t[i] = t[i] + 1;
               if (t[i] == 8 * (divs[i] + 1)) begin
                 phase[i] = 2; mdata[i] = capw[i];
               end
             end
          default: if (ack[i]) begin
               if (start[i]) begin
                 phase[i] = 1; t[i] = 0; capw[i] = word[i];
               end else begin
                 phase[i] = 0;
               end
             end
        endcase
      end
    end
    cyc = cyc + 1;
  end

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[u%0d]: got %0h expected %0h at %0t", nm, i, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk("sel", i, 32'(sel[i]), (phase[i] == 1) ? 32'(t[i] / (divs[i] + 1)) : 32'd0);
        chk("busy", i, 32'(busy[i]), 32'(phase[i] == 1));
        chk("valid", i, 32'(valid[i]), 32'(phase[i] == 2));
        chk("data_out", i, 32'(data_out[i]), 32'(mdata[i]));
`ifdef SCAN_PARITY_EN
        chk("parity", i, 32'(parity[i]), 32'(^mdata[i]));
`endif
      end
    end
  end

  // Called on a falling edge; the start is accepted on edge s+1.
  task automatic do_start(input int i, input logic a, input logic [7:0] w, output int s);
    word[i]  = w;
    start[i] = 1'b1;
    ack[i]   = a;
    s        = cyc;
    @(negedge clk);
    start[i] = 1'b0;
    ack[i]   = 1'b0;
  endtask

  task automatic wait_valid(input int i, input int lim, input int s, input int lat, input string nm);
    int n = 0;
    while (!valid[i] && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (!valid[i]) begin
      total++;
      bad++;
      $display("FAIL %s[u%0d]: valid never rose within %0d cycles", nm, i, lim);
    end else begin
      chk(nm, i, 32'(cyc - (s + 1)), 32'(lat));
    end
  endtask

  task automatic pulse_ack(input int i);
    ack[i] = 1'b1;
    @(negedge clk);
    ack[i] = 1'b0;
  endtask

  initial begin
    int s;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; ack[i] = 1'b0; word[i] = 8'h00;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_sel", 0, 32'(sel[0]), 32'd0);
    chk("rst_valid", 1, 32'(valid[1]), 32'd0);
    chk("rst_data", 0, 32'(data_out[0]), 32'd0);
    chk_en = 1'b1;
    @(negedge clk);

    // Basic scan, DIV=0.
    do_start(0, 1'b0, 8'hA5, s);
    wait_valid(0, 40, s, 8, "lat_div0");
    chk("data_a5", 0, 32'(data_out[0]), 32'h0000_00A5);
    pulse_ack(0);
    chk("ack_to_idle", 0, 32'(valid[0]), 32'd0);
    ack[0] = 1'b1;
    repeat (2) @(negedge clk);
    ack[0] = 1'b0;

    // Prescaled scan, DIV=3, with a start pulse mid-scan that must be ignored.
    do_start(1, 1'b0, 8'h3C, s);
    repeat (5) @(negedge clk);
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    wait_valid(1, 100, s, 32, "lat_div3");
    chk("data_3c", 1, 32'(data_out[1]), 32'h0000_003C);
    pulse_ack(1);

    // Held result: starts without ack are ignored.
    do_start(0, 1'b0, 8'h07, s);
    wait_valid(0, 40, s, 8, "lat_07");
    for (int k = 0; k < 10; k++) begin
      start[0] = (k % 2 == 0);
      @(negedge clk);
    end
    start[0] = 1'b0;
    chk("hold_valid", 0, 32'(valid[0]), 32'd1);
    chk("hold_data", 0, 32'(data_out[0]), 32'h0000_0007);
    chk("hold_busy", 0, 32'(busy[0]), 32'd0);
`ifdef SCAN_PARITY_EN
    chk("parity_07", 0, 32'(parity[0]), 32'd1);
`endif

    // Back-to-back: ack with start launches the next scan directly.
    do_start(0, 1'b1, 8'h5A, s);
    wait_valid(0, 40, s, 8, "lat_b2b");
    chk("data_5a", 0, 32'(data_out[0]), 32'h0000_005A);
    pulse_ack(0);
    do_start(0, 1'b0, 8'hFF, s);
    wait_valid(0, 40, s, 8, "lat_ff");
    chk("data_ff", 0, 32'(data_out[0]), 32'h0000_00FF);
`ifdef SCAN_PARITY_EN
    chk("parity_ff", 0, 32'(parity[0]), 32'd0);
`endif
    pulse_ack(0);

    // Asynchronous reset in the middle of a scan.
    do_start(0, 1'b0, 8'h96, s);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_sel", 0, 32'(sel[0]), 32'd0);
    chk("arst_busy", 0, 32'(busy[0]), 32'd0);
    chk("arst_data", 0, 32'(data_out[0]), 32'd0);
    chk("arst_data", 1, 32'(data_out[1]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("no_valid_after_rst", 0, 32'(valid[0]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
